// File: rtl/fcp6_req_arbiter.sv
// fcp6_req_arbiter: round-robin arbiter that serialises N requesters onto one FCP6 master,
// sequencing the start pulse and busy/ack handshake with a completion timeout.
module fcp6_req_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [8*N-1:0] hdr,
   input  logic [8*N-1:0] wdata,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   done,
   output logic [7:0]     rdata,
   output logic           err,
   output logic           arb_busy,
   output logic           m_start,
   output logic [7:0]     m_header,
   output logic [7:0]     m_data,
   input  logic           m_busy,
   input  logic           m_ack,
   input  logic [7:0]     m_rdata
);

   localparam int unsigned   IW     = $clog2(N);
   localparam int unsigned   TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [IW-1:0] N_LAST = IW'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] ptr, win, pick, cand;
   logic          found;
   logic [TW-1:0] timer;
   logic          timed_out;

   // First set request at or after ptr, wrapping modulo N.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = IW'((32'(ptr) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      timed_out = (timer == T_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      m_start   = 1'b0;
      arb_busy  = 1'b1;
      done      = '0;
      case (state)
         IDLE: begin
            arb_busy = 1'b0;
            if (found) state_nxt = LAUNCH;
         end
         LAUNCH: begin
            m_start   = 1'b1;
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (m_busy)         state_nxt = WAIT_DONE;
            else if (timed_out) state_nxt = RESP;
         end
         WAIT_DONE: begin
            if (!m_busy || timed_out) state_nxt = RESP;
         end
         RESP: begin
            done      = gnt;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Timer runs through both wait states and stops at T_LAST, so it cannot wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt      <= '0;
         rdata    <= '0;
         err      <= 1'b0;
         m_header <= '0;
         m_data   <= '0;
         ptr      <= '0;
         win      <= '0;
         timer    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  win      <= pick;
                  gnt      <= N'(1) << pick;
                  m_header <= hdr[8*pick +: 8];
                  m_data   <= wdata[8*pick +: 8];
               end
            end
            LAUNCH: begin
               timer <= '0;
               err   <= 1'b0;
               rdata <= '0;
            end
            WAIT_BUSY: begin
               if (!timed_out)   timer <= timer + TW'(1);
               else if (!m_busy) err   <= 1'b1;
            end
            WAIT_DONE: begin
               if (!m_busy) begin
                  rdata <= m_rdata;
                  err   <= ~m_ack;
               end else if (timed_out) begin
                  rdata <= '0;
                  err   <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RESP: begin
               gnt <= '0;
               ptr <= (win == N_LAST) ? '0 : win + IW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fcp6_req_arbiter.sv
// Self-checking bench for fcp6_req_arbiter: a behavioural FCP6 master plus a
// scoreboard of expected completions, checked when done pulses.
module tb_fcp6_req_arbiter;

   localparam int N       = 4;
   localparam int TIMEOUT = 64;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [8*N-1:0] hdr;
   logic [8*N-1:0] wdata;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic [7:0]     rdata;
   logic           err;
   logic           arb_busy;
   logic           m_start;
   logic [7:0]     m_header;
   logic [7:0]     m_data;
   logic           m_busy;
   logic           m_ack;
   logic [7:0]     m_rdata;

   fcp6_req_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .hdr(hdr), .wdata(wdata),
      .gnt(gnt), .done(done), .rdata(rdata), .err(err), .arb_busy(arb_busy),
      .m_start(m_start), .m_header(m_header), .m_data(m_data),
      .m_busy(m_busy), .m_ack(m_ack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [7:0] hd;
      logic [7:0] wd;
      logic [7:0] rd;
      logic       e;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Master model: mode 0 = busy for mst_len cycles, 1 = never busy, 2 = busy stuck high.
   int         mst_mode    = 0;
   int         mst_len     = 2;
   logic       mst_ack     = 1'b1;
   logic [7:0] mst_rd      = 8'h00;
   logic       mst_release = 1'b0;
   int         mst_cnt;

   initial begin
      m_busy  = 1'b0;
      m_ack   = 1'b0;
      m_rdata = 8'h00;
      mst_cnt = 0;
      forever begin
         @(negedge clk);
         if (mst_release) begin
            m_busy = 1'b0;
         end else if (m_start === 1'b1) begin
            if (mst_mode != 1) begin
               m_busy  = 1'b1;
               mst_cnt = mst_len;
            end
         end else if (m_busy && mst_mode == 0) begin
            mst_cnt--;
            if (mst_cnt <= 0) begin
               m_busy  = 1'b0;
               m_ack   = mst_ack;
               m_rdata = mst_rd;
            end
         end
      end
   end

   // Waits (bounded) for a done pulse; optionally drops req/hdr of one requester mid-transaction.
   task automatic collect(input int limit, input int drop_at, input int drop_idx,
                          output logic ok, output logic [N-1:0] d, output logic [7:0] rd,
                          output logic e, output int nstart, output int lat,
                          output logic held, output logic [7:0] mh, output logic [7:0] md);
      logic started;
      started = 1'b0; ok = 1'b0; d = '0; rd = 8'h00; e = 1'b0;
      nstart = 0; lat = -1; held = 1'b1; mh = 8'h00; md = 8'h00;
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         if (m_start === 1'b1) begin
            nstart++;
            if (!started) begin
               started = 1'b1;
               mh = m_header;
               md = m_data;
               lat = 0;
            end
         end else if (started) begin
            lat++;
         end
         if (started && (m_header !== mh || m_data !== md)) held = 1'b0;
         if (started && lat == drop_at) begin
            req[drop_idx] = 1'b0;
            hdr[8*drop_idx +: 8] = ~hdr[8*drop_idx +: 8];
         end
         if (done !== '0) begin
            ok = 1'b1; d = done; rd = rdata; e = err;
            break;
         end
      end
   endtask

   function automatic logic [N-1:0] onehot(input int idx);
      logic [N-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   logic         c_ok, c_held, c_e;
   logic [N-1:0] c_d;
   logic [7:0]   c_rd, c_mh, c_md;
   int           c_ns, c_lat;
   exp_t         x;

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({gnt, done, rdata, err, arb_busy, m_start, m_header, m_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got gnt=%b done=%b rdata=%h err=%b busy=%b start=%b hdr=%h data=%h required all 0",
                  gnt, done, rdata, err, arb_busy, m_start, m_header, m_data);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (arb_busy !== 1'b0 || gnt !== '0) begin
         errors++;
         $display("FAIL idle_no_req: got busy=%b gnt=%b required 0/0", arb_busy, gnt);
      end
   endtask

   task automatic test_round_robin;
      int order[8];
      order = '{0, 1, 2, 3, 0, 1, 3, 1};
      mst_mode = 0; mst_len = 3; mst_ack = 1'b1; mst_rd = 8'h5A;
      for (int i = 0; i < N; i++) begin
         hdr[8*i +: 8]   = 8'h10 + 8'(i);
         wdata[8*i +: 8] = 8'h20 + 8'(i);
      end
      req = 4'b1111;
      for (int k = 0; k < 6; k++)
         sb.push_back('{order[k], 8'h10 + 8'(order[k]), 8'h20 + 8'(order[k]), 8'h5A, 1'b0, 4});
      for (int k = 0; k < 8; k++) begin
         if (k == 6) begin
            req = 4'b1010;
            sb.push_back('{order[6], 8'h13, 8'h23, 8'h5A, 1'b0, 4});
            sb.push_back('{order[7], 8'h11, 8'h21, 8'h5A, 1'b0, 4});
         end
         collect(100, -1, 0, c_ok, c_d, c_rd, c_e, c_ns, c_lat, c_held, c_mh, c_md);
         if (k == 6) req[3] = 1'b0;
         if (k == 7) req = '0;
         x = sb.pop_front();
         checks++;
         if (!c_ok || c_d !== onehot(x.idx) || c_mh !== x.hd || c_md !== x.wd ||
             c_rd !== x.rd || c_e !== x.e || c_lat != x.lat) begin
            errors++;
            $display("FAIL rr_grant%0d: got ok=%b done=%b hdr=%h data=%h rdata=%h err=%b lat=%0d required done=%b hdr=%h data=%h rdata=%h err=%b lat=%0d",
                     k, c_ok, c_d, c_mh, c_md, c_rd, c_e, c_lat,
                     onehot(x.idx), x.hd, x.wd, x.rd, x.e, x.lat);
         end
      end
   endtask

   task automatic test_single;
      mst_mode = 0; mst_len = 10; mst_ack = 1'b1; mst_rd = 8'hA5;
      hdr[7:0] = 8'b01100111; wdata[7:0] = 8'hA5;
      req = 4'b0001;
      sb.push_back('{0, 8'b01100111, 8'hA5, 8'hA5, 1'b0, 11});
      collect(100, -1, 0, c_ok, c_d, c_rd, c_e, c_ns, c_lat, c_held, c_mh, c_md);
      req = '0;
      x = sb.pop_front();
      checks++;
      if (!c_ok || c_d !== onehot(x.idx)) begin
         errors++;
         $display("FAIL single_done: got ok=%b done=%b required done=%b", c_ok, c_d, onehot(x.idx));
      end
      checks++;
      if (c_ns != 1) begin
         errors++;
         $display("FAIL single_start_count: got %0d required 1", c_ns);
      end
      checks++;
      if (!c_held || c_md !== x.wd || c_mh !== x.hd) begin
         errors++;
         $display("FAIL single_hold: got held=%b hdr=%h data=%h required held=1 hdr=%h data=%h",
                  c_held, c_mh, c_md, x.hd, x.wd);
      end
      checks++;
      if (c_rd !== x.rd || c_e !== x.e || c_lat != x.lat) begin
         errors++;
         $display("FAIL single_resp: got rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=%0d",
                  c_rd, c_e, c_lat, x.rd, x.e, x.lat);
      end
   endtask

   task automatic test_nack;
      mst_mode = 0; mst_len = 4; mst_ack = 1'b0; mst_rd = 8'h3C;
      hdr[31:24] = 8'hC3; wdata[31:24] = 8'h77;
      req = 4'b1000;
      sb.push_back('{3, 8'hC3, 8'h77, 8'h3C, 1'b1, 5});
      collect(100, -1, 0, c_ok, c_d, c_rd, c_e, c_ns, c_lat, c_held, c_mh, c_md);
      req = '0;
      x = sb.pop_front();
      checks++;
      if (!c_ok || c_d !== onehot(x.idx) || c_rd !== x.rd || c_e !== x.e || c_lat != x.lat) begin
         errors++;
         $display("FAIL nack: got ok=%b done=%b rdata=%h err=%b lat=%0d required done=%b rdata=%h err=%b lat=%0d",
                  c_ok, c_d, c_rd, c_e, c_lat, onehot(x.idx), x.rd, x.e, x.lat);
      end
      mst_ack = 1'b1;
   endtask

   task automatic test_timeout;
      for (int m = 1; m <= 2; m++) begin
         mst_mode = m; mst_rd = 8'hFF; mst_ack = 1'b1;
         hdr[23:16] = 8'h40 + 8'(m); wdata[23:16] = 8'h50 + 8'(m);
         req = 4'b0100;
         sb.push_back('{2, 8'h40 + 8'(m), 8'h50 + 8'(m), 8'h00, 1'b1, TIMEOUT + 1});
         collect(300, -1, 0, c_ok, c_d, c_rd, c_e, c_ns, c_lat, c_held, c_mh, c_md);
         req = '0;
         x = sb.pop_front();
         checks++;
         if (!c_ok || c_d !== onehot(x.idx) || c_rd !== x.rd || c_e !== x.e || c_lat != x.lat) begin
            errors++;
            $display("FAIL timeout_mode%0d: got ok=%b done=%b rdata=%h err=%b lat=%0d required done=%b rdata=%h err=%b lat=%0d",
                     m, c_ok, c_d, c_rd, c_e, c_lat, onehot(x.idx), x.rd, x.e, x.lat);
         end
         mst_release = 1'b1;
         repeat (2) @(negedge clk);
         mst_release = 1'b0;
         mst_mode = 0;
      end
   endtask

   task automatic test_req_drop;
      mst_mode = 0; mst_len = 8; mst_ack = 1'b1; mst_rd = 8'h77;
      hdr[15:8] = 8'h91; wdata[15:8] = 8'h19;
      req = 4'b0010;
      sb.push_back('{1, 8'h91, 8'h19, 8'h77, 1'b0, 9});
      collect(100, 4, 1, c_ok, c_d, c_rd, c_e, c_ns, c_lat, c_held, c_mh, c_md);
      x = sb.pop_front();
      checks++;
      if (!c_ok || c_d !== onehot(x.idx) || !c_held || c_mh !== x.hd || c_rd !== x.rd || c_lat != x.lat) begin
         errors++;
         $display("FAIL req_drop: got ok=%b done=%b held=%b hdr=%h rdata=%h lat=%0d required done=%b held=1 hdr=%h rdata=%h lat=%0d",
                  c_ok, c_d, c_held, c_mh, c_rd, c_lat, onehot(x.idx), x.hd, x.rd, x.lat);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (gnt !== '0 || arb_busy !== 1'b0) begin
         errors++;
         $display("FAIL req_drop_idle: got gnt=%b busy=%b required 0/0", gnt, arb_busy);
      end
   endtask

   task automatic test_reset_mid;
      logic seen;
      mst_mode = 2;
      hdr[23:16] = 8'hB2;
      req = 4'b0100;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (m_start === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rstmid_launch: got no m_start required m_start within 20 cycles");
      end
      repeat (4) @(negedge clk);
      checks++;
      if (arb_busy !== 1'b1 || m_busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_in_wait: got busy=%b m_busy=%b required 1/1", arb_busy, m_busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({gnt, done, rdata, err, arb_busy, m_start, m_header, m_data} !== '0) begin
         errors++;
         $display("FAIL rstmid_async: got gnt=%b done=%b rdata=%h err=%b busy=%b start=%b hdr=%h data=%h required all 0",
                  gnt, done, rdata, err, arb_busy, m_start, m_header, m_data);
      end
      mst_release = 1'b1;
      repeat (2) @(negedge clk);
      mst_release = 1'b0;
      mst_mode = 0; mst_len = 2; mst_ack = 1'b1; mst_rd = 8'hE1;
      checks++;
      if (done !== '0) begin
         errors++;
         $display("FAIL rstmid_no_done: got done=%b required 0", done);
      end
      hdr[7:0] = 8'h0D; wdata[7:0] = 8'hD0;
      req = 4'b1111;
      rst = 1'b1;
      sb.push_back('{0, 8'h0D, 8'hD0, 8'hE1, 1'b0, 3});
      collect(100, -1, 0, c_ok, c_d, c_rd, c_e, c_ns, c_lat, c_held, c_mh, c_md);
      req = '0;
      x = sb.pop_front();
      checks++;
      if (!c_ok || c_d !== onehot(x.idx) || c_mh !== x.hd || c_rd !== x.rd || c_e !== x.e || c_lat != x.lat) begin
         errors++;
         $display("FAIL rstmid_first_grant: got ok=%b done=%b hdr=%h rdata=%h err=%b lat=%0d required done=%b hdr=%h rdata=%h err=%b lat=%0d",
                  c_ok, c_d, c_mh, c_rd, c_e, c_lat, onehot(x.idx), x.hd, x.rd, x.e, x.lat);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst   = 1'b0;
      req   = '0;
      hdr   = '0;
      wdata = '0;
      test_reset;
      test_round_robin;
      test_single;
      test_nack;
      test_timeout;
      test_req_drop;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
